// File: rtl/step_loader.sv
// Deserialises narrow stream words into full step records behind a one-entry valid/ready output register.
// Optional STEP_LOADER_CSUM_EN: each record carries a trailing XOR checksum word; bad records are dropped and flag err.
module step_loader #(
  parameter int STEP_W = 560,
  parameter int WORD_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [STEP_W-1:0] step,
  output logic              step_valid,
  input  logic              step_ready,
  output logic [CNT_W-1:0]  step_count,
  output logic              err
);

  localparam int NWORDS = (STEP_W + WORD_W - 1) / WORD_W;
  localparam int ASM_W  = NWORDS * WORD_W;
`ifdef STEP_LOADER_CSUM_EN
  localparam int LAST = NWORDS;
`else
  localparam int LAST = NWORDS - 1;
`endif
  localparam int IDX_W = $clog2(LAST + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [ASM_W-1:0] asm_q;
  logic [ASM_W-1:0] asm_wr;
  logic             accept;
  logic             rec_ok;

  assign accept = in_valid && in_ready;

  // Assembly register with the incoming word merged, so completion can bypass asm_q.
  // The checksum trailer index (NWORDS) matches no slot and leaves asm_q untouched.
  always_comb begin
    asm_wr = asm_q;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (cnt == IDX_W'(i)) asm_wr[i*WORD_W +: WORD_W] = in_word;
    end
  end

`ifdef STEP_LOADER_CSUM_EN
  logic [WORD_W-1:0] csum_q;
  assign rec_ok = (in_word == csum_q);
`else
  assign rec_ok = 1'b1;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FILL;
      cnt        <= '0;
      asm_q      <= '0;
      in_ready   <= 1'b0;
      step       <= '0;
      step_valid <= 1'b0;
      step_count <= '0;
`ifdef STEP_LOADER_CSUM_EN
      csum_q     <= '0;
      err        <= 1'b0;
`endif
    end else begin
      if (step_valid && step_ready) begin
        step_valid <= 1'b0;
        step_count <= step_count + CNT_W'(1);
      end
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            asm_q <= asm_wr;
`ifdef STEP_LOADER_CSUM_EN
            csum_q <= csum_q ^ in_word;
`endif
            if (cnt == IDX_W'(LAST)) begin
              cnt <= '0;
`ifdef STEP_LOADER_CSUM_EN
              csum_q <= '0;
`endif
              if (rec_ok) begin
                if (!step_valid || step_ready) begin
                  step       <= asm_wr[STEP_W-1:0];
                  step_valid <= 1'b1;
                end else begin
                  state    <= HOLD;
                  in_ready <= 1'b0;
                end
              end else begin
`ifdef STEP_LOADER_CSUM_EN
                err <= 1'b1;
`endif
              end
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (step_ready) begin
            step       <= asm_q[STEP_W-1:0];
            step_valid <= 1'b1;
            state      <= FILL;
            in_ready   <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
